// File: rtl/mult_div_unit.sv
// Execute-stage multiply/divide unit: owns HI/LO, runs fixed-latency MULT/DIV
// operations, and handles MTHI/MTLO writes and the MFHI/MFLO read mux.
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [3:0]  MDUOP,
  input  logic [3:0]  Time,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [1:0]  ReadHILO,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MDUOut
);

  localparam int CW = 8;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;

  typedef enum logic {IDLE = 1'b0, CALC = 1'b1} state_e;

  state_e      state_q;
  logic        busy_q;
  logic [CW-1:0] cnt_q;
  logic [31:0] hi_q, lo_q;
  logic [31:0] hi_pend_q, lo_pend_q;
  logic        wr_pend_q;

  logic        is_md_d;
  logic [CW-1:0] lat_d;
  logic [31:0] res_hi_d, res_lo_d;
  logic        res_wr_d;

  logic [63:0] prod_s_d, prod_u_d;
  logic [31:0] a_mag_d, b_mag_d, b_safe_d, bu_safe_d;
  logic [31:0] q_mag_d, r_mag_d;

  function automatic logic [31:0] abs32(input logic [31:0] v);
    abs32 = v[31] ? (32'd0 - v) : v;
  endfunction

  // Decode the request and pick the latency for a new operation.
  always_comb begin
    is_md_d = (MDUOP == OP_MULT) || (MDUOP == OP_MULTU) ||
              (MDUOP == OP_DIV)  || (MDUOP == OP_DIVU);
    if (Time != 4'd0) begin
      lat_d = {4'd0, Time};
    end else if ((MDUOP == OP_MULT) || (MDUOP == OP_MULTU)) begin
      lat_d = CW'(MULT_CYCLES);
    end else begin
      lat_d = CW'(DIV_CYCLES);
    end
  end

  // Compute the full result up front; it sits in the pending registers until commit.
  always_comb begin
    prod_s_d  = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    prod_u_d  = {32'd0, A} * {32'd0, B};
    a_mag_d   = abs32(A);
    b_mag_d   = abs32(B);
    // A zero divisor is replaced by one so the dividers never see 0; the
    // result is then suppressed via res_wr_d.
    b_safe_d  = (b_mag_d == 32'd0) ? 32'd1 : b_mag_d;
    bu_safe_d = (B == 32'd0) ? 32'd1 : B;
    q_mag_d   = a_mag_d / b_safe_d;
    r_mag_d   = a_mag_d % b_safe_d;
    res_hi_d  = 32'd0;
    res_lo_d  = 32'd0;
    res_wr_d  = 1'b1;
    case (MDUOP)
      OP_MULT: begin
        res_hi_d = prod_s_d[63:32];
        res_lo_d = prod_s_d[31:0];
      end
      OP_MULTU: begin
        res_hi_d = prod_u_d[63:32];
        res_lo_d = prod_u_d[31:0];
      end
      OP_DIV: begin
        res_lo_d = (A[31] ^ B[31]) ? (32'd0 - q_mag_d) : q_mag_d;
        res_hi_d = A[31] ? (32'd0 - r_mag_d) : r_mag_d;
        res_wr_d = (B != 32'd0);
      end
      OP_DIVU: begin
        res_lo_d = A / bu_safe_d;
        res_hi_d = A % bu_safe_d;
        res_wr_d = (B != 32'd0);
      end
      default: begin
        res_wr_d = 1'b0;
      end
    endcase
  end

  // Control FSM with HI/LO ownership; MT writes and Start are only honoured in IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      busy_q    <= 1'b0;
      cnt_q     <= '0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      hi_pend_q <= 32'd0;
      lo_pend_q <= 32'd0;
      wr_pend_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (Start && is_md_d) begin
            hi_pend_q <= res_hi_d;
            lo_pend_q <= res_lo_d;
            wr_pend_q <= res_wr_d;
            cnt_q     <= lat_d;
            busy_q    <= 1'b1;
            state_q   <= CALC;
          end else if (MDUOP == OP_MTHI) begin
            hi_q <= A;
          end else if (MDUOP == OP_MTLO) begin
            lo_q <= A;
          end else begin
            busy_q <= 1'b0;
          end
        end
        CALC: begin
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            if (wr_pend_q) begin
              hi_q <= hi_pend_q;
              lo_q <= lo_pend_q;
            end
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  // Read mux looks only at committed registers, never the pending values.
  always_comb begin
    case (ReadHILO)
      2'b01:   MDUOut = hi_q;
      2'b10:   MDUOut = lo_q;
      default: MDUOut = 32'd0;
    endcase
  end

  assign Busy = busy_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: stimulus pushes expected commits, a
// monitor pops and checks them whenever Busy drops.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        Start;
  logic [3:0]  MDUOP;
  logic [3:0]  Time;
  logic [31:0] A, B;
  logic [1:0]  ReadHILO;
  logic        Busy;
  logic [31:0] HI, LO, MDUOut;

  mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .Start(Start), .MDUOP(MDUOP), .Time(Time),
    .A(A), .B(B), .ReadHILO(ReadHILO), .Busy(Busy), .HI(HI), .LO(LO),
    .MDUOut(MDUOut)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  int          tests = 0;
  int          fails = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  function automatic logic [31:0] rd_model(input logic [1:0] sel, input logic [31:0] h, input logic [31:0] l);
    if (sel == 2'b01) return h;
    else if (sel == 2'b10) return l;
    else return 32'd0;
  endfunction

  // Architectural reference: plain 64-bit integer arithmetic.
  function automatic void model(input int op, input logic [31:0] a, input logic [31:0] b,
                                inout logic [31:0] h, inout logic [31:0] l);
    longint          p, q, r;
    longint unsigned pu;
    case (op)
      1: begin p = longint'($signed(a)) * longint'($signed(b)); h = p[63:32]; l = p[31:0]; end
      2: begin pu = longint'(a) * longint'(b); h = pu[63:32]; l = pu[31:0]; end
      3: if (b != 32'd0) begin
           q = longint'($signed(a)) / longint'($signed(b));
           r = longint'($signed(a)) % longint'($signed(b));
           l = q[31:0]; h = r[31:0];
         end
      4: if (b != 32'd0) begin l = a / b; h = a % b; end
      default: ;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int op, input logic [31:0] a, input logic [31:0] b, input logic [3:0] t);
    exp_t e;
    logic [31:0] h, l;
    h = m_hi; l = m_lo;
    model(op, a, b, h, l);
    e.hi = h; e.lo = l;
    e.lat = (t != 4'd0) ? int'(t) : ((op <= 2) ? 5 : 10);
    sb.push_back(e);
    m_hi = h; m_lo = l;
    Start = 1'b1; MDUOP = op[3:0]; A = a; B = b; Time = t;
    tick();
    Start = 1'b0; MDUOP = 4'd0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((sb.size() != 0 || Busy) && n < 64) begin
      tick();
      n++;
    end
    if (n >= 64) begin
      tests++; fails++;
      $display("FAIL wait_idle: timeout with %0d pending", sb.size());
    end
  endtask

  task automatic mt(input int op, input logic [31:0] a, input logic st);
    Start = st; MDUOP = op[3:0]; A = a;
    tick();
    Start = 1'b0; MDUOP = 4'd0;
    if (op == 5) m_hi = a; else m_lo = a;
  endtask

  // Monitor: Busy falling edge marks a commit (or abort) to be checked.
  initial begin
    int   busy_len = 0;
    logic prev_busy = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (Busy === 1'b1) begin
        busy_len++;
      end else if (prev_busy) begin
        if (sb.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_op: got busy_len %0d expected no operation", busy_len);
        end else begin
          e = sb.pop_front();
          chk("commit_hi", HI, e.hi);
          chk("commit_lo", LO, e.lo);
          chk("busy_len", busy_len, e.lat);
          chk("commit_mduout", MDUOut, rd_model(ReadHILO, e.hi, e.lo));
        end
        busy_len = 0;
      end
      prev_busy = (Busy === 1'b1);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          seen;
    int          r, op;
    logic [31:0] a, b;
    reset = 1'b1; Start = 1'b0; MDUOP = 4'd0; Time = 4'd0;
    A = 32'd0; B = 32'd0; ReadHILO = 2'b10;
    tick(); tick(); tick();
    reset = 1'b0;
    chk("rst_hi", HI, 32'd0);
    chk("rst_lo", LO, 32'd0);
    chk("rst_busy", {31'd0, Busy}, 32'd0);
    chk("rst_mduout", MDUOut, 32'd0);

    issue(1, 32'hFFFFFFFE, 32'd3, 4'd5);
    wait_idle();
    chk("mult_lo", LO, 32'hFFFFFFFA);
    chk("mult_hi", HI, 32'hFFFFFFFF);

    issue(3, 32'hFFFFFFF9, 32'd2, 4'd0);
    wait_idle();
    chk("div_lo", LO, 32'hFFFFFFFD);
    chk("div_hi", HI, 32'hFFFFFFFF);
    issue(4, 32'hFFFFFFF9, 32'd2, 4'd0);
    wait_idle();
    chk("divu_lo", LO, 32'h7FFFFFFC);
    chk("divu_hi", HI, 32'd1);

    // MTHI: same-cycle read sees the old HI.
    ReadHILO = 2'b01; MDUOP = 4'd5; A = 32'h12345678;
    #1;
    chk("mthi_old_read", MDUOut, m_hi);
    tick();
    MDUOP = 4'd0; m_hi = 32'h12345678;
    chk("mthi_hi", HI, 32'h12345678);
    chk("mthi_busy", {31'd0, Busy}, 32'd0);

    // MTLO during CALC is ignored.
    ReadHILO = 2'b10;
    issue(1, 32'd3, 32'd4, 4'd4);
    MDUOP = 4'd6; A = 32'h0000DEAD;
    tick();
    MDUOP = 4'd0;
    wait_idle();
    chk("mtlo_busy_lo", LO, 32'd12);

    mt(6, 32'h0000AAAA, 1'b0);
    mt(5, 32'h00005555, 1'b1);
    chk("mt_start_busy", {31'd0, Busy}, 32'd0);
    issue(3, 32'd77, 32'd0, 4'd0);
    wait_idle();
    chk("div0_hi", HI, 32'h00005555);
    chk("div0_lo", LO, 32'h0000AAAA);

    // Reset in the third Busy cycle discards the MULTU.
    begin
      exp_t e;
      issue(2, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'd0);
      e = sb.pop_back();
      e.hi = 32'd0; e.lo = 32'd0; e.lat = 3;
      sb.push_back(e);
      m_hi = 32'd0; m_lo = 32'd0;
    end
    tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_busy", {31'd0, Busy}, 32'd0);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (Busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) seen++;
    end
    chk("abort_no_commit", seen, 0);

    // Start on the commit cycle is ignored.
    issue(3, 32'h80000000, 32'hFFFFFFFF, 4'd3);
    tick(); tick();
    Start = 1'b1; MDUOP = 4'd1; A = 32'd5; B = 32'd7; Time = 4'd2;
    tick();
    Start = 1'b0; MDUOP = 4'd0;
    chk("ovf_lo", LO, 32'h80000000);
    chk("ovf_hi", HI, 32'd0);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (Busy !== 1'b0) seen++;
    end
    chk("commit_start_ignored", seen, 0);
    wait_idle();

    for (int it = 0; it < 40; it++) begin
      r = $urandom_range(0, 9);
      ReadHILO = 2'($urandom_range(0, 3));
      if (r <= 5) begin
        op = $urandom_range(1, 4);
        a = $urandom;
        b = $urandom;
        if ($urandom_range(0, 5) == 0) b = 32'd0;
        else if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 9));
        if ($urandom_range(0, 9) == 0) begin a = 32'h80000000; b = 32'hFFFFFFFF; end
        issue(op, a, b, 4'($urandom_range(0, 6)));
        wait_idle();
      end else if (r <= 7) begin
        op = $urandom_range(5, 6);
        mt(op, $urandom, 1'($urandom_range(0, 1)));
        chk("rand_mt_hi", HI, m_hi);
        chk("rand_mt_lo", LO, m_lo);
        chk("rand_mt_busy", {31'd0, Busy}, 32'd0);
      end else begin
        Start = 1'b1;
        MDUOP = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(7, 15));
        A = $urandom; B = $urandom;
        tick();
        Start = 1'b0; MDUOP = 4'd0;
        chk("rand_nop_busy", {31'd0, Busy}, 32'd0);
        chk("rand_nop_hi", HI, m_hi);
        chk("rand_nop_lo", LO, m_lo);
      end
      chk("rand_mduout", MDUOut, rd_model(ReadHILO, m_hi, m_lo));
    end

    wait_idle();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Execute-stage multiply/divide unit. It consumes the Start / MDUOP / Time / ReadHILO control produced by the decode-stage control unit.
- It owns the HI and LO registers, runs MULT/MULTU/DIV/DIVU as fixed-latency multi-cycle operations, and performs MTHI/MTLO writes.
- It reports Busy so the hazard unit can stall later MD-class instructions.
- It drives MDUOut for MFHI/MFLO writeback.

Parameters:
- MULT_CYCLES, 5, latency used for MULT/MULTU when Time==0.
- DIV_CYCLES, 10, latency used for DIV/DIVU when Time==0.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- Start  input  1  begin a MULT/MULTU/DIV/DIVU in this cycle (E-stage).
- MDUOP  input  4  0=none, 1=MULT, 2=MULTU, 3=DIV, 4=DIVU, 5=MTHI, 6=MTLO; 7-15 treated as none.
- Time  input  4  operation latency in cycles; 0 selects the parameter default.
- A  input  32  rs operand (forwarded).
- B  input  32  rt operand (forwarded).
- ReadHILO  input  2  01=HI, 10=LO, 00/11 -> MDUOut=0.
- Busy  output  1  operation in flight.
- HI  output  32  architectural HI register.
- LO  output  32  architectural LO register.
- MDUOut  output  32  combinational read of HI/LO per ReadHILO.

Behaviour:
- One clock, clk; reset is synchronous, active-high.
- Reset (sampled at a posedge, including mid-operation):
  - HI=0, LO=0, Busy=0, counter=0, state=IDLE.
  - Any in-flight result is discarded, and HI/LO are not updated by it.

States:
- IDLE:
  - Start=1 with MDUOP in 1..4 at posedge N: latch the result into HIpend/LOpend, load counter=T (T=Time, or the default if Time==0), go to CALC.
  - Start=1 with MDUOP not in 1..4: ignored.
- CALC:
  - Busy=1 during cycles N+1 .. N+T.
  - Counter decrements each posedge.
  - At the posedge ending cycle N+T (counter==1): HI<=HIpend, LO<=LOpend, Busy->0, go to IDLE.
  - New HI/LO are visible from cycle N+T+1.
- Busy is a registered output and is 0 in IDLE.
- The hazard unit must stall on (Busy | Start). The unit itself ignores Start, MTHI and MTLO while in CALC; HI/LO keep their pending-commit values.

Arithmetic:
- MULT: {HI,LO} = signed A * signed B, full 64 bits.
- MULTU: {HI,LO} = unsigned 64-bit product.
- DIV:
  - LO = quotient truncated toward zero; HI = remainder with the sign of the dividend A.
  - A=0x80000000, B=0xFFFFFFFF gives LO=0x80000000, HI=0.
- DIVU: LO = A/B, HI = A%B, unsigned.
- B==0 for DIV/DIVU: full Busy latency still occurs; HI and LO remain unchanged at commit.

MTHI/MTLO:
- MDUOP=5 or 6 (Start not required) in IDLE: HI<=A or LO<=A at that posedge.
- Busy is not asserted.
- If Start=1 with MDUOP 5/6 in the same cycle, the MT write occurs and no operation starts.

MDUOut:
- Combinational from the current HI/LO registers, never from pending values.
- A read in the same cycle as an MTHI/MTLO write returns the old value.

Simultaneous events:
- reset beats everything.
- Commit and a new Start in the same cycle (counter==1): the Start is ignored, because the state is still CALC.

Test Plan:
1. MULT A=0xFFFFFFFE(-2), B=3, Time=5, Start=1 at cycle 0 -> Busy=1 cycles 1-5, 0 at cycle 6; HI=0xFFFFFFFF, LO=0xFFFFFFFA from cycle 6; MDUOut(ReadHILO=10)=0xFFFFFFFA.
2. DIV A=0xFFFFFFF9(-7), B=2, Time=0 -> Busy for 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF. Then DIVU with the same operands -> LO=0x7FFFFFFC, HI=1.
3. MTHI A=0x12345678 -> HI=0x12345678 next cycle with Busy=0. MTLO while Busy=1 -> LO unchanged after commit.
4. DIV B=0 after MTLO 0xAAAA / MTHI 0x5555 -> Busy 10 cycles, then HI=0x5555, LO=0xAAAA.
5. MULTU 0xFFFFFFFF*0xFFFFFFFF; reset asserted in the 3rd Busy cycle -> next cycle Busy=0, HI=LO=0, and no later commit.
6. DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0. Start pulsed on the commit cycle -> ignored, and Busy stays 0 afterwards.
